mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 2, number of wait cycles between read address issue and mem_rdata valid; legal range 0..7.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 i_req  in  1  instruction-fetch read request, held until i_ack.
REQ-006 i_addr  in  32  fetch byte address.
REQ-007 i_ack  out  1  one-cycle fetch completion pulse.
REQ-008 i_rdata  out  32  fetch read data, valid while i_ack=1.
REQ-009 d_req  in  1  data request, held until d_ack.
REQ-010 d_we  in  1  1=write, 0=read.
REQ-011 d_addr  in  32  data byte address.
REQ-012 d_wdata  in  32  write data.
REQ-013 d_ack  out  1  one-cycle data completion pulse.
REQ-014 d_rdata  out  32  data read result, valid while d_ack=1.
REQ-015 mem_addr  out  32  address to the single-port memory.
REQ-016 mem_wr  out  1  memory write strobe; 0 means read.
REQ-017 mem_wdata  out  32  memory write data.
REQ-018 mem_rdata  in  32  memory read data, valid LATENCY cycles after issue.
REQ-019 busy  out  1  1 when state is not IDLE.
REQ-020 state_out  out  2  current state encoding: IDLE=0, BUSY=1, RESP=2.

Function
REQ-021 The FSM SHALL have states IDLE, BUSY and RESP; encoding 3 is unreachable and SHALL return to IDLE.
REQ-022 In IDLE, at a clock edge with a request pending (edge E0), the arbiter SHALL grant one requester, latch its address, we and wdata and owner, and go to BUSY.
REQ-023 Arbitration when only one request is pending: that requester is granted.
REQ-024 Arbitration when both requests are pending: grant the requester not granted most recently (round-robin); last-grant resets to I, so D wins the first contention.
REQ-025 On grant, counter SHALL load LATENCY for reads and 0 for writes.
REQ-026 In BUSY with counter>0, each edge SHALL decrement the counter.
REQ-027 In BUSY with counter=0, the edge SHALL capture mem_rdata into the shared read register (reads only; unchanged on writes) and go to RESP.
REQ-028 In RESP, the granted requester's ack SHALL be 1 for exactly one cycle; the other ack SHALL be 0; the next edge SHALL go to IDLE unconditionally.
REQ-029 Read ack SHALL rise at E0+LATENCY+1; write ack SHALL rise at E0+1.
REQ-030 mem_addr and mem_wdata SHALL drive the latched values at all times, holding them after completion.
REQ-031 mem_wr SHALL be 1 only during BUSY of a write (exactly one cycle), otherwise 0.
REQ-032 i_rdata and d_rdata SHALL both drive the shared read register.
REQ-033 A request dropped mid-transaction SHALL be ignored: the transaction completes and ack still pulses.
REQ-034 Requests are sampled only in IDLE, so at least one IDLE cycle separates transactions; minimum read period is LATENCY+3 cycles.
REQ-035 Addresses pass unmodified; no alignment checking.

Reset
REQ-036 While reset=0, the block SHALL immediately force state IDLE, counter 0, acks 0, mem_wr 0, busy 0, state_out 0, the read register 0, mem_addr 0, mem_wdata 0 and last-grant I, regardless of clock.
REQ-037 Reset asserted mid-transaction SHALL abort the transaction with no ack after release unless a new request is made.

Verification
REQ-038 LATENCY=2, i_req with i_addr=0x00000004, memory returns 0x8C220010 -> i_ack high at E0+3 for one cycle, i_rdata=0x8C220010, mem_wr never 1.
REQ-039 d_req write with d_addr=0x00000100, d_wdata=0xDEADBEEF -> mem_wr=1 for one cycle with mem_addr=0x100 and mem_wdata=0xDEADBEEF, d_ack at E0+1.
REQ-040 i_req and d_req held high continuously from reset release -> grant order D, I, D, I; each ack pulses exactly once per grant.
REQ-041 Reset pulled low during BUSY of a read -> acks 0, mem_wr 0 and state_out=0 immediately; no ack is seen after release while requests stay low.
REQ-042 LATENCY=0 read -> ack at E0+1 carrying the mem_rdata present during BUSY.
REQ-043 i_req held through ack for back-to-back reads at LATENCY=2 -> i_ack pulses exactly 5 cycles apart.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request ports and single-port memory bus of the arbiter
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Arbiter side: takes requests and memory data, drives acks and the memory bus.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_wr, mem_wdata
  );

  // Requester/memory side.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter in front of a fixed-latency single-port memory
module mem_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  mem_arbiter_if.slave bus,
  output logic        busy,
  output logic [1:0]  state_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [2:0] READ_WAIT = 3'(LATENCY);

  logic [1:0]  state;
  logic [2:0]  count;
  logic        owner;
  logic        last_grant;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        grant_d;

  // Data side wins when it is the only requester, or on contention when fetch was granted last.
  always_comb begin
    grant_d = bus.d_req && (!bus.i_req || (last_grant == OWN_I));
  end

  // Transaction FSM: grant and latch in IDLE, count down memory latency in BUSY, ack in RESP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= 3'd0;
      owner      <= OWN_I;
      last_grant <= OWN_I;
      we         <= 1'b0;
      addr       <= 32'd0;
      wdata      <= 32'd0;
      rdata      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            state      <= BUSY;
            owner      <= grant_d;
            last_grant <= grant_d;
            if (grant_d) begin
              addr  <= bus.d_addr;
              we    <= bus.d_we;
              wdata <= bus.d_wdata;
              count <= bus.d_we ? 3'd0 : READ_WAIT;
            end else begin
              // Fetches never write; the previous write data stays on the bus.
              addr  <= bus.i_addr;
              we    <= 1'b0;
              count <= READ_WAIT;
            end
          end
        end
        BUSY: begin
          if (count != 3'd0) begin
            count <= count - 3'd1;
          end else begin
            if (!we) begin
              rdata <= bus.mem_rdata;
            end
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.mem_wr    = (state == BUSY) && we;
  assign bus.i_ack     = (state == RESP) && (owner == OWN_I);
  assign bus.d_ack     = (state == RESP) && (owner == OWN_D);
  assign bus.i_rdata   = rdata;
  assign bus.d_rdata   = rdata;
  assign busy          = (state != IDLE);
  assign state_out     = state;

endmodule
